// File: rtl/cut_controller_if.sv
// rtl/cut_controller_if.sv - cut sequencer command/status and cut-driver handshake bundle
// slave: the controller itself; master: the sequencing FSM plus cut driver side.
interface cut_controller_if #(
  parameter int CNT_W = 8
);
  logic             start_i;
  logic [CNT_W-1:0] num_cuts_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [CNT_W-1:0] cuts_done_o;
  logic             cut_o;
  logic             cut_end_i;

  modport slave (
    input  start_i, num_cuts_i, abort_i, cut_end_i,
    output busy_o, done_o, err_o, cuts_done_o, cut_o
  );

  modport master (
    output start_i, num_cuts_i, abort_i, cut_end_i,
    input  busy_o, done_o, err_o, cuts_done_o, cut_o
  );
endinterface

// File: rtl/cut_controller.sv
// rtl/cut_controller.sv - issues a commanded number of cuts with idle gaps and a response timeout
// One counter serves both the ISSUE timeout and the GAP length; it is cleared on every state entry.
module cut_controller #(
  parameter int CNT_W          = 8,
  parameter int GAP_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TO_W           = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  cut_controller_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, ERROR} state_e;

  localparam logic [TO_W-1:0] GAP_LAST = TO_W'(GAP_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] cuts_done_q;
  logic [TO_W-1:0]  cnt_q;
  logic             cut_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;

  logic [CNT_W-1:0] cuts_inc_d;
  logic [TO_W-1:0]  cnt_inc_d;

  assign cuts_inc_d = cuts_done_q + CNT_W'(1);
  assign cnt_inc_d  = cnt_q + TO_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      target_q    <= '0;
      cuts_done_q <= '0;
      cnt_q       <= '0;
      cut_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            target_q    <= bus.num_cuts_i;
            cuts_done_q <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            if (bus.num_cuts_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ISSUE;
              cut_q   <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          cnt_q <= cnt_inc_d;
          // A completion always counts, even when it lands on an abort or timeout edge.
          if (bus.cut_end_i) begin
            cuts_done_q <= cuts_inc_d;
            cut_q       <= 1'b0;
            cnt_q       <= '0;
            if (bus.abort_i || (cuts_inc_d == target_q)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= !bus.abort_i;
            end else begin
              state_q <= GAP;
            end
          end else if (bus.abort_i) begin
            state_q <= IDLE;
            cut_q   <= 1'b0;
            busy_q  <= 1'b0;
          end else if (cnt_q == TO_LAST) begin
            state_q <= ERROR;
            cut_q   <= 1'b0;
            err_q   <= 1'b1;
          end
        end
        GAP: begin
          cnt_q <= cnt_inc_d;
          if (bus.abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == GAP_LAST) begin
            state_q <= ISSUE;
            cut_q   <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ERROR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          cut_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.err_o       = err_q;
  assign bus.cuts_done_o = cuts_done_q;
  assign bus.cut_o       = cut_q;

endmodule

// File: tb/tb_cut_controller.sv
// tb/tb_cut_controller.sv - randomized directed bench for cut_controller with a cut-driver model
// Expected waveforms are built from cut latencies and gap length, one cycle per array slot.
module tb_cut_controller;
  localparam int CNT_W = 8;
  localparam int GAP   = 4;
  localparam int TO    = 50;
  localparam int MAXT  = 400;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cut_controller_if #(.CNT_W(CNT_W)) bus ();

  cut_controller #(
    .CNT_W(CNT_W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO), .TO_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic drv_end  = 1'b0;
  logic spur_end = 1'b0;
  assign bus.cut_end_i = drv_end | spur_end;

  int checks   = 0;
  int failures = 0;

  bit   drv_en = 1'b1;
  int   lat[8];
  int   rise_idx = 0;
  int   rem = 0;
  logic prev_cut = 1'b0;

  logic [31:0] e_cut[MAXT];
  logic [31:0] e_done[MAXT];
  logic [31:0] e_busy[MAXT];
  logic [31:0] e_cnt[MAXT];

  // Cut driver: answers lat[k] cycles after the k-th rise of cut_o in a sequence.
  always @(negedge clk) begin
    drv_end = 1'b0;
    if (!rst_n || !bus.busy_o) begin
      rem      = 0;
      rise_idx = 0;
    end else begin
      if (!bus.cut_o) begin
        rem = 0;
      end else if (!prev_cut && drv_en) begin
        rem      = lat[rise_idx & 7];
        rise_idx = rise_idx + 1;
      end
      if (rem > 0) begin
        rem = rem - 1;
        if (rem == 0) drv_end = 1'b1;
      end
    end
    prev_cut = bus.cut_o;
  end

  task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
    end
  endtask

  task automatic build_model(input int n, input int abort_t, output int len);
    int t;
    logic [31:0] frz;
    for (int i = 0; i < MAXT; i++) begin
      e_cut[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_cnt[i] = n;
    end
    t = 0;
    if (n == 0) e_done[0] = 1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < lat[i]; k++) begin
        e_cut[t] = 1; e_busy[t] = 1; e_cnt[t] = i; t++;
      end
      if (i == n - 1) e_done[t] = 1;
      else for (int g = 0; g < GAP; g++) begin
        e_busy[t] = 1; e_cnt[t] = i + 1; t++;
      end
    end
    len = t + 3;
    if (abort_t >= 0) begin
      frz = e_cnt[abort_t + 1];
      for (int i = abort_t + 1; i < MAXT; i++) begin
        e_cut[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_cnt[i] = frz;
      end
      len = abort_t + 4;
    end
  endtask

  task automatic run_trace(input int n, input int abort_t, input int bst_t, input int spur_t);
    int len;
    build_model(n, abort_t, len);
    @(negedge clk);
    bus.start_i    = 1'b1;
    bus.num_cuts_i = CNT_W'(n);
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int t = 0; t < len; t++) begin
      chk("cut_o", t, 32'(bus.cut_o), e_cut[t]);
      chk("done_o", t, 32'(bus.done_o), e_done[t]);
      chk("busy_o", t, 32'(bus.busy_o), e_busy[t]);
      chk("cuts_done_o", t, 32'(bus.cuts_done_o), e_cnt[t]);
      chk("err_o", t, 32'(bus.err_o), 32'd0);
      bus.abort_i = (t == abort_t);
      bus.start_i = (t == bst_t);
      if (t == bst_t) bus.num_cuts_i = CNT_W'(1);
      spur_end = (t == spur_t);
      @(negedge clk);
    end
    bus.abort_i = 1'b0;
    bus.start_i = 1'b0;
    spur_end    = 1'b0;
  endtask

  initial begin
    int n;
    int abort_t;
    bus.start_i    = 1'b0;
    bus.num_cuts_i = '0;
    bus.abort_i    = 1'b0;
    for (int i = 0; i < 8; i++) lat[i] = 10;

    @(negedge clk);
    chk("rst_cut_o", 0, 32'(bus.cut_o), 32'd0);
    chk("rst_busy_o", 0, 32'(bus.busy_o), 32'd0);
    chk("rst_done_o", 0, 32'(bus.done_o), 32'd0);
    chk("rst_err_o", 0, 32'(bus.err_o), 32'd0);
    chk("rst_cuts_done_o", 0, 32'(bus.cuts_done_o), 32'd0);
    rst_n = 1'b1;

    // Three cuts at the nominal 10-cycle driver latency.
    run_trace(3, -1, -1, -1);

    // Random counts and latencies, with a spurious cut_end_i in the first gap.
    repeat (3) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) lat[i] = $urandom_range(1, 12);
      run_trace(n, -1, -1, (n > 1) ? lat[0] + 1 : -1);
    end

    // Completion on the very edge the timeout would fire.
    lat[0] = TO;
    lat[1] = $urandom_range(1, 5);
    run_trace(2, -1, -1, -1);

    // Five-cut sequence: ignored start during the first cut, abort inside the second gap.
    for (int i = 0; i < 8; i++) lat[i] = $urandom_range(1, 12);
    abort_t = lat[0] + GAP + lat[1] + $urandom_range(0, GAP - 1);
    run_trace(5, abort_t, $urandom_range(0, lat[0] - 1), -1);
    chk("abort_cuts_done_o", 0, 32'(bus.cuts_done_o), 32'd2);

    // Spurious completion while idle.
    spur_end = 1'b1;
    @(negedge clk);
    spur_end = 1'b0;
    @(negedge clk);
    chk("idle_spur_cuts_done_o", 0, 32'(bus.cuts_done_o), 32'd2);
    chk("idle_spur_busy_o", 0, 32'(bus.busy_o), 32'd0);
    chk("idle_spur_cut_o", 0, 32'(bus.cut_o), 32'd0);

    // Driver never answers.
    drv_en = 1'b0;
    bus.start_i    = 1'b1;
    bus.num_cuts_i = CNT_W'(3);
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int t = 0; t < TO + 6; t++) begin
      chk("to_cut_o", t, 32'(bus.cut_o), 32'(t < TO));
      chk("to_err_o", t, 32'(bus.err_o), 32'(t >= TO));
      chk("to_busy_o", t, 32'(bus.busy_o), 32'(t <= TO));
      chk("to_done_o", t, 32'(bus.done_o), 32'd0);
      chk("to_cuts_done_o", t, 32'(bus.cuts_done_o), 32'd0);
      @(negedge clk);
    end
    drv_en = 1'b1;

    // Zero cuts, which also clears the sticky error.
    run_trace(0, -1, -1, -1);

    // Asynchronous reset while the second cut is in flight.
    for (int i = 0; i < 8; i++) lat[i] = 10;
    bus.start_i    = 1'b1;
    bus.num_cuts_i = CNT_W'(2);
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (17) @(negedge clk);
    chk("pre_rst_cut_o", 0, 32'(bus.cut_o), 32'd1);
    chk("pre_rst_cuts_done_o", 0, 32'(bus.cuts_done_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cut_o", 0, 32'(bus.cut_o), 32'd0);
    chk("arst_busy_o", 0, 32'(bus.busy_o), 32'd0);
    chk("arst_done_o", 0, 32'(bus.done_o), 32'd0);
    chk("arst_err_o", 0, 32'(bus.err_o), 32'd0);
    chk("arst_cuts_done_o", 0, 32'(bus.cuts_done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_cut_o", 0, 32'(bus.cut_o), 32'd0);
    chk("post_rst_busy_o", 0, 32'(bus.busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cut_controller.md
Name:
cut_controller

Overview:
- Initiator side of the cut handshake. Sequences a commanded number of cuts by raising `cut_o` toward the cut driver and waiting for the driver's `cut_end_i` completion pulse before starting the next cut.
- Inserts a fixed idle gap between cuts.
- Counts completed cuts.
- Flags a timeout if the driver never answers.
- Sits between the top-level cutting-machine FSM and `cut_driver`.

Parameters:
- CNT_W, 8, width of the cut-count request and the completed-cut counter.
- GAP_CYCLES, 100, number of clock cycles `cut_o` is held low between consecutive cuts (minimum 1).
- TIMEOUT_CYCLES, 1000000, maximum cycles `cut_o` may stay high without `cut_end_i` before the controller errors out.
- TO_W, 20, width of the shared gap/timeout counter (must hold TIMEOUT_CYCLES-1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  one-cycle request to begin a cut sequence; sampled only in IDLE
- num_cuts_i  input  CNT_W  number of cuts; latched when start_i is accepted
- abort_i  input  1  stop the sequence; active in any non-IDLE state
- busy_o  output  1  high while not in IDLE
- done_o  output  1  one-cycle pulse when the sequence completes normally
- err_o  output  1  sticky timeout flag; cleared on the next accepted start_i
- cuts_done_o  output  CNT_W  number of cuts completed in the current or last sequence
- cut_o  output  1  level request to cut_driver; high = perform a cut
- cut_end_i  input  1  completion pulse from cut_driver, sampled on rising clk

Behaviour:
- Reset values, asynchronous on rst_n=0: state=IDLE; cut_o=0, busy_o=0, done_o=0, err_o=0, cuts_done_o=0; internal counters=0.
- All outputs are registered. A reset mid-sequence drops cut_o immediately and discards the sequence.
- States: IDLE, ISSUE, GAP, ERROR.
- IDLE:
  - start_i=1 latches num_cuts_i into `target` and clears cuts_done_o and err_o.
  - If num_cuts_i==0: stay IDLE and pulse done_o on the next cycle; cut_o never rises.
  - Otherwise go to ISSUE. cut_o is 1 in the cycle after start_i is sampled (1-cycle latency).
  - cut_end_i is ignored in IDLE.
- ISSUE:
  - cut_o=1; the timeout counter increments every cycle.
  - On cut_end_i=1, cuts_done_o increments at that edge and cut_o=0 from the next cycle. Then:
    - if cuts_done_o+1==target, go to IDLE and pulse done_o for one cycle;
    - else go to GAP with the counter cleared.
  - If the counter reaches TIMEOUT_CYCLES-1 with no cut_end_i, go to ERROR.
  - cut_end_i on the same edge as the timeout wins: it counts as completion, no error.
- GAP:
  - cut_o=0; the counter increments.
  - After exactly GAP_CYCLES cycles low, return to ISSUE with the counter cleared.
  - cut_end_i in GAP is ignored (spurious) and does not count.
- ERROR: lasts one cycle. Sets err_o=1 and cut_o=0, then goes to IDLE. done_o is not pulsed.
- abort_i (ISSUE/GAP):
  - Go to IDLE next cycle with cut_o=0 and no done_o.
  - If cut_end_i arrives on the same edge as abort_i, the cut is still counted.
- start_i while busy_o=1 is ignored.
- cuts_done_o never exceeds target. The counter does not wrap, because target is at most 2^CNT_W-1.

Test Plan:
- Common setup: GAP_CYCLES=4, TIMEOUT_CYCLES=50, and a behavioural driver model that pulses cut_end_i 10 cycles after each cut_o rise.
- Normal 3-cut sequence:
  - Stimulus: start_i with num_cuts_i=3.
  - Required: cut_o rises 1 cycle after start and shows 3 high periods of 10 cycles separated by exactly 4 low cycles.
  - Required: cuts_done_o steps 1,2,3; done_o is a single-cycle pulse after the 3rd cut_end_i; busy_o then falls; err_o=0.
- Zero cuts:
  - Stimulus: start_i with num_cuts_i=0.
  - Required: cut_o stays 0, done_o pulses 1 cycle later, cuts_done_o=0.
- Timeout:
  - Stimulus: the driver model never responds.
  - Required: cut_o stays high for 50 cycles then drops; err_o=1, busy_o=0, no done_o.
  - Follow-up: the next start_i clears err_o.
- Abort and ignored start:
  - Stimulus: abort_i during the 2nd GAP of a 5-cut sequence.
  - Required: cut_o stays 0, cuts_done_o=2, busy_o falls next cycle, no done_o.
  - Stimulus: start_i while busy_o=1.
  - Required: ignored; target is unchanged.
- Spurious and boundary cut_end_i:
  - Stimulus: cut_end_i pulses in IDLE and GAP.
  - Required: no count and no state change.
  - Stimulus: cut_end_i coincident with the timeout edge.
  - Required: counted; err_o stays 0.
- Reset mid-ISSUE:
  - Stimulus: rst_n=0 while cut_o=1.
  - Required: cut_o=0 immediately (asynchronous) and all outputs return to their reset values.
